// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 selector: select type, channel codes, channel count.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH0 = 2'd0;
  localparam sel_t SEL_CH1 = 2'd1;
  localparam sel_t SEL_CH2 = 2'd2;
  localparam sel_t SEL_CH3 = 2'd3;

  localparam int N_CH = 4;

endpackage : mux_pkg

// File: rtl/mux4_to_1_core.sv
// Pure combinational 4:1 channel selector; channel k sits at d[k*WIDTH +: WIDTH].
module mux4_to_1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [N_CH*WIDTH-1:0] d,
  input  sel_t                  sel,
  output logic [WIDTH-1:0]      y
);

  // The 'x default covers only an unknown select; every legal code has its own arm.
  always_comb begin
    y = 'x;
    case (sel)
      SEL_CH0: y = d[0*WIDTH +: WIDTH];
      SEL_CH1: y = d[1*WIDTH +: WIDTH];
      SEL_CH2: y = d[2*WIDTH +: WIDTH];
      SEL_CH3: y = d[3*WIDTH +: WIDTH];
    endcase
  end

endmodule : mux4_to_1_core

// File: rtl/mux4_to_1.sv
// 4:1 selector with a combinational output y and a one-cycle registered copy y_q/sel_q/vld_q.
module mux4_to_1
  import mux_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] d,
  input  sel_t                  sel,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic [WIDTH-1:0]      y_q,
  output sel_t                  sel_q,
  output logic                  vld_q
);

  mux4_to_1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .d   (d),
    .sel (sel),
    .y   (y)
  );

  // en is a plain capture qualifier with no back-pressure: a capture happens on every
  // rising edge with rst_n=1 and en=1, and vld_q marks the cycle after each such capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= RST_VAL;
      sel_q <= SEL_CH0;
      vld_q <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= sel;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

endmodule : mux4_to_1

// File: tb/tb_mux4_to_1.sv
// Self-checking bench for mux4_to_1 at WIDTH=1 and WIDTH=8 against a behavioural model.
module tb_mux4_to_1;
  import mux_pkg::*;

  localparam logic [7:0] RST8 = 8'h3C;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  sel_t        sel;
  logic [3:0]  d1;
  logic [31:0] d8;

  logic       y1, yq1, vld1;
  sel_t       selq1, selq8;
  logic [7:0] y8, yq8;
  logic       vld8;

  mux4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .sel(sel), .en(en),
    .y(y1), .y_q(yq1), .sel_q(selq1), .vld_q(vld1)
  );

  mux4_to_1 #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .sel(sel), .en(en),
    .y(y8), .y_q(yq8), .sel_q(selq8), .vld_q(vld8)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  logic       m_yq1;
  logic [7:0] m_yq8;
  sel_t       m_selq;
  logic       m_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic ref1(input logic [3:0] d, input int s);
    return d[s];
  endfunction

  function automatic logic [7:0] ref8(input logic [31:0] d, input int s);
    logic [31:0] sh;
    sh = d >> (8 * s);
    return sh[7:0];
  endfunction

  // driver: apply one cycle of inputs, check y, then the registered outputs after the edge
  task automatic cycle(input logic r, input logic e, input sel_t s,
                       input logic [3:0] a1, input logic [31:0] a8);
    logic [7:0] exp8;
    rst_n = r; en = e; sel = s; d1 = a1; d8 = a8;
    #1;
    check("y1", {31'd0, y1}, {31'd0, ref1(a1, int'(s))});
    check("y8", {24'd0, y8}, {24'd0, ref8(a8, int'(s))});
    if (!r) begin
      m_yq1 = 1'b0; m_yq8 = RST8; m_selq = 2'd0; m_vld = 1'b0;
    end else if (e) begin
      m_yq1 = ref1(a1, int'(s)); m_yq8 = ref8(a8, int'(s)); m_selq = s; m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    exp_q.push_back(m_yq8);
    @(posedge clk);
    #1;
    exp8 = exp_q.pop_front();
    check("yq1",   {31'd0, yq1},   {31'd0, m_yq1});
    check("selq1", {30'd0, selq1}, {30'd0, m_selq});
    check("vld1",  {31'd0, vld1},  {31'd0, m_vld});
    check("yq8",   {24'd0, yq8},   {24'd0, exp8});
    check("selq8", {30'd0, selq8}, {30'd0, m_selq});
    check("vld8",  {31'd0, vld8},  {31'd0, m_vld});
  endtask

  logic [7:0] w8_exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 2'd0; d1 = 4'd0; d8 = 32'd0;
    m_yq1 = 1'b0; m_yq8 = RST8; m_selq = 2'd0; m_vld = 1'b0;

    // exhaustive truth table, WIDTH=1
    for (int dv = 0; dv < 16; dv++) begin
      for (int s = 0; s < 4; s++) begin
        d1 = 4'(dv); sel = 2'(s);
        #1;
        check("tt", {31'd0, y1}, {31'd0, ref1(4'(dv), s)});
      end
    end
    d1 = 4'b1010; sel = 2'd1; #1; check("tt_ex01", {31'd0, y1}, 32'd1);
    sel = 2'd0;               #1; check("tt_ex00", {31'd0, y1}, 32'd0);
    sel = 2'd3;               #1; check("tt_ex11", {31'd0, y1}, 32'd1);

    // free-running toggle pattern: d[k] period 2^(k+1), sel steps every 16
    for (int t = 0; t < 64; t++) begin
      d1  = {1'((t >> 3) & 1), 1'((t >> 2) & 1), 1'((t >> 1) & 1), 1'(t & 1)};
      sel = 2'((t / 16) % 4);
      #1;
      check("toggle", {31'd0, y1}, {31'd0, ref1(d1, (t / 16) % 4)});
    end

    // WIDTH=8 channel placement
    d8 = 32'hDDCCBBAA;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("w8", {24'd0, y8}, {24'd0, w8_exp[s]});
    end

    @(posedge clk); #1;

    // reset held for two edges with en=1, d=F, sel=3
    cycle(1'b0, 1'b1, 2'd3, 4'hF, 32'hDDCCBBAA);
    cycle(1'b0, 1'b1, 2'd3, 4'hF, 32'hDDCCBBAA);

    // latency, then hold with en=0
    cycle(1'b1, 1'b1, 2'd2, 4'b0100, 32'h11223344);
    cycle(1'b1, 1'b0, 2'd2, 4'b0000, 32'h00000000);

    // mid-operation reset for exactly one edge
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom), $urandom);
    cycle(1'b0, 1'b1, 2'd1, 4'hF, 32'hFFFFFFFF);
    cycle(1'b1, 1'b1, 2'd1, 4'b0010, 32'h0000A500);

    // randomized stream
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 15) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
            4'($urandom), $urandom);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux4_to_1

// File: doc/mux4_to_1.md
Name: mux4_to_1

Overview:
- Four-input, one-output selector. Output y carries input channel d[sel]; y_q is a registered copy of the same selection.
- General-purpose leaf block in the digital-electronics library: data-path steering and lab exercises.
- Combinational path (y) reproduces the classic 4:1 mux truth table.
- Registered path (y_q, sel_q, vld_q) gives a timing-clean output with one-cycle latency.

Parameters:
- WIDTH, 1, bit width of each data channel and of y / y_q.
- RST_VAL, 0 (WIDTH bits), value loaded into y_q on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- d  input  4*WIDTH  packed channels; channel k occupies d[k*WIDTH +: WIDTH], so channel 0 is in the LSBs.
- sel  input  2  channel select, binary 0..3.
- en  input  1  capture enable for the registered path.
- y  output  WIDTH  combinational d[sel].
- y_q  output  WIDTH  registered selection.
- sel_q  output  2  sel value captured alongside y_q.
- vld_q  output  1  high for one cycle after each enabled capture.

Behaviour:
- y = channel[sel], purely combinational, zero latency, independent of clk, rst_n and en.
  - sel=00 → d[0]; sel=01 → d[1]; sel=10 → d[2]; sel=11 → d[3].
  - Any change on d or sel propagates to y in the same delta/time step.
- All 4 sel codes are valid; no undefined or default case.
  - If sel contains X/Z, y is X in simulation.
  - RTL must use a full case, so no latches are inferred.
- Registered path, evaluated on rising clk:
  - rst_n=0: y_q ← RST_VAL, sel_q ← 0, vld_q ← 0. Reset overrides en.
  - rst_n=1, en=1: y_q ← channel[sel], sel_q ← sel, vld_q ← 1.
  - rst_n=1, en=0: y_q and sel_q hold, vld_q ← 0.
- Latency: y_q equals the y value present just before the capturing edge, one cycle after sampling.
- Reset asserted mid-stream clears y_q / sel_q / vld_q at that edge; the combinational y keeps operating.
- Reset deasserts synchronously; the first capture can occur on the first edge with rst_n=1 and en=1.
- Outputs y_q, sel_q and vld_q are undefined before the first clock edge. Only the post-reset state is specified.
- No handshake back-pressure; en is a plain qualifier.

Decomposition:
- Shared package mux_pkg holds:
  - typedef sel_t (logic [1:0]);
  - constants SEL_CH0..SEL_CH3 = 0..3;
  - N_CH = 4.
- One natural sub-module, mux4_to_1_core: the pure combinational selector, parameterized by WIDTH.
- Top level = core + output register stage.

Test Plan:
- Exhaustive truth table, WIDTH=1: for all 16 d values × 4 sel values, y == d[sel]. Example: d=4'b1010, sel=01 → y=1; sel=00 → y=0; sel=11 → y=1.
- Free-running toggle stimulus, checked continuously; y must always equal d[sel], with zero mismatches over 64 ns:
  - d[0] period 2 ns, d[1] 4 ns, d[2] 8 ns, d[3] 16 ns;
  - sel starts at 00 and increments every 16 ns, wrapping 11→00.
- Reset: hold rst_n=0 for 2 edges with en=1, d=4'hF, sel=11 → y_q=RST_VAL=0, sel_q=0, vld_q=0, while y=1.
- Latency: rst_n=1, en=1, sel=10, d=4'b0100 at edge N → y_q=1, sel_q=10, vld_q=1 after edge N. Then set en=0 and d=0 → y_q holds 1, vld_q=0 on the next edge.
- Mid-operation reset: stream with en=1, then drop rst_n for exactly one edge → that edge clears all registers. The next edge with rst_n=1 captures d[sel] normally.
- WIDTH=8: d = {8'hDD, 8'hCC, 8'hBB, 8'hAA} (channel 3 in the MSBs) → sel=0..3 gives y = AA, BB, CC, DD respectively.
